bin_upsample2x: RTL

- 2x2 nearest-neighbour unpooling for the BWN 1-bit feature-map stream; the inverse-direction partner of the 2x2 binary max-pool.
- Takes a WIDTH x HEIGHT raster stream and emits a 2*WIDTH x 2*HEIGHT raster stream.
- Each input pixel is repeated horizontally. Each output row pair is built by one live pass and one replay from an internal row buffer.
- Sits on the decoder/expansion side of the BWN datapath; valid/ready on both sides.

---
 rtl/bin_upsample2x.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/bin_upsample2x.sv
// 2x2 nearest-neighbour unpooling: each pixel is emitted twice per row, and every row is replayed once from a line buffer.
// One-cycle latency from accept to oDATA; the output register holds under iREADY=0, and input is stalled during the copy and replay slots.
module bin_upsample2x #(
  parameter int WL     = 1,
  parameter int WIDTH  = 8,
  parameter int HEIGHT = 8
) (
  input  logic          iCLK,
  input  logic          iRST,
  input  logic          iSTART,
  input  logic          iVALID,
  input  logic [WL-1:0] iDATA,
  output logic          oREADY,
  output logic          oVALID,
  output logic [WL-1:0] oDATA,
  input  logic          iREADY,
  output logic          oLAST,
  output logic          oDONE
);

  localparam int CW = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
  localparam int RW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam logic [CW-1:0] COL_MAX = CW'(WIDTH - 1);
  localparam logic [RW-1:0] ROW_MAX = RW'(HEIGHT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROW_A = 2'd1,
    ROW_B = 2'd2
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] col, col_nxt;
  logic [RW-1:0] row, row_nxt;
  logic          phase, phase_nxt;
  logic          valid_nxt, last_nxt, done_nxt;
  logic [WL-1:0] data_nxt;
  logic          slot_free, accept;

  logic [WL-1:0] row_mem [WIDTH];

  assign slot_free = !oVALID || iREADY;
  // A start pulse outside IDLE restarts the frame, so nothing is taken in that cycle.
  assign oREADY    = (state == ROW_A) && !phase && slot_free && !iSTART;
  assign accept    = iVALID && oREADY;

  always_comb begin
    state_nxt = state;
    col_nxt   = col;
    row_nxt   = row;
    phase_nxt = phase;
    valid_nxt = oVALID;
    data_nxt  = oDATA;
    last_nxt  = oLAST;
    done_nxt  = oVALID && iREADY && oLAST;

    if (oVALID && iREADY) begin
      last_nxt = 1'b0;
    end

    if (iSTART && (state != IDLE)) begin
      state_nxt = ROW_A;
      col_nxt   = '0;
      row_nxt   = '0;
      phase_nxt = 1'b0;
      valid_nxt = 1'b0;
      last_nxt  = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (slot_free) begin
            valid_nxt = 1'b0;
          end
          if (iSTART) begin
            state_nxt = ROW_A;
            col_nxt   = '0;
            row_nxt   = '0;
            phase_nxt = 1'b0;
          end
        end

        ROW_A: begin
          if (!phase) begin
            if (accept) begin
              data_nxt  = iDATA;
              valid_nxt = 1'b1;
              phase_nxt = 1'b1;
            end else if (slot_free) begin
              valid_nxt = 1'b0;
            end
          end else if (slot_free) begin
            valid_nxt = 1'b1;
            phase_nxt = 1'b0;
            if (col == COL_MAX) begin
              col_nxt   = '0;
              state_nxt = ROW_B;
            end else begin
              col_nxt = col + CW'(1);
            end
          end
        end

        ROW_B: begin
          if (slot_free) begin
            data_nxt  = row_mem[col];
            valid_nxt = 1'b1;
            phase_nxt = !phase;
            if (phase) begin
              if (col == COL_MAX) begin
                col_nxt = '0;
                if (row == ROW_MAX) begin
                  state_nxt = IDLE;
                  row_nxt   = '0;
                  last_nxt  = 1'b1;
                end else begin
                  row_nxt   = row + RW'(1);
                  state_nxt = ROW_A;
                end
              end else begin
                col_nxt = col + CW'(1);
              end
            end
          end
        end

        default: begin
          state_nxt = IDLE;
          valid_nxt = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      state  <= IDLE;
      col    <= '0;
      row    <= '0;
      phase  <= 1'b0;
      oVALID <= 1'b0;
      oDATA  <= '0;
      oLAST  <= 1'b0;
      oDONE  <= 1'b0;
    end else begin
      state  <= state_nxt;
      col    <= col_nxt;
      row    <= row_nxt;
      phase  <= phase_nxt;
      oVALID <= valid_nxt;
      oDATA  <= data_nxt;
      oLAST  <= last_nxt;
      oDONE  <= done_nxt;
    end
  end

  // Line buffer needs no reset: every entry is written in ROW_A before ROW_B reads it.
  always_ff @(posedge iCLK) begin
    if (accept) begin
      row_mem[col] <= iDATA;
    end
  end

endmodule
